// File: rtl/cv32e40x_xif_commit_tracker_if.sv
// Purpose: bundles the issue, commit and execute/drop signals of the commit tracker.
// Latency: none; this interface only carries signals.
// Backpressure: issue uses issue_ready_o, execute uses exec_ready_i, and drops are never stalled.
interface cv32e40x_xif_commit_tracker_if #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned ID_WIDTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic                issue_valid_i;
    logic                issue_ready_o;
    logic [ID_WIDTH-1:0] issue_id_i;
    logic                commit_valid_i;
    logic [ID_WIDTH-1:0] commit_id_i;
    logic                commit_kill_i;
    logic                exec_valid_o;
    logic                exec_ready_i;
    logic [ID_WIDTH-1:0] exec_id_o;
    logic                drop_valid_o;
    logic [ID_WIDTH-1:0] drop_id_o;
    logic [CW-1:0]       count_o;
    logic                commit_error_o;

    // Tracker side.
    modport slave (
        input  issue_valid_i, issue_id_i, commit_valid_i, commit_id_i, commit_kill_i, exec_ready_i,
        output issue_ready_o, exec_valid_o, exec_id_o, drop_valid_o, drop_id_o, count_o, commit_error_o
    );

    // Core / execution-unit side.
    modport master (
        output issue_valid_i, issue_id_i, commit_valid_i, commit_id_i, commit_kill_i, exec_ready_i,
        input  issue_ready_o, exec_valid_o, exec_id_o, drop_valid_o, drop_id_o, count_o, commit_error_o
    );
endinterface

// File: rtl/cv32e40x_xif_commit_tracker.sv
// Purpose: an in-order table of offloaded IDs that releases committed entries to execution and discards killed entries.
// Latency: a commit or kill on the head shows on exec/drop one cycle later, and a push shows in count_o one cycle later.
// Backpressure: issue stalls when the table is full, exec holds while exec_ready_i is low, and drops never stall.
module cv32e40x_xif_commit_tracker #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned ID_WIDTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    cv32e40x_xif_commit_tracker_if.slave     xif
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        SLOT_FREE      = 2'd0,
        SLOT_PENDING   = 2'd1,
        SLOT_COMMITTED = 2'd2,
        SLOT_KILLED    = 2'd3
    } slot_state_e;

    slot_state_e         state_q [DEPTH];
    slot_state_e         state_d [DEPTH];
    logic [ID_WIDTH-1:0] id_q    [DEPTH];
    logic [ID_WIDTH-1:0] id_d    [DEPTH];
    logic [PW-1:0]       hd_q, hd_d, tl_q, tl_d;
    logic [CW-1:0]       count_q, count_d;
    logic                err_q, err_d;

    slot_state_e         head_state;
    slot_state_e         resolve_state;
    logic                exec_vld, drop_vld, issue_rdy;
    logic                push, pop;
    logic                hit_tbl, hit_push;

    // Head status and handshakes. These depend only on registered state and the
    // issue/exec strobes, so no commit input reaches an output.
    always_comb begin
        head_state = state_q[hd_q];
        exec_vld   = (head_state == SLOT_COMMITTED);
        drop_vld   = (head_state == SLOT_KILLED);
        issue_rdy  = (count_q < CW'(DEPTH));
        push       = xif.issue_valid_i && issue_rdy;
        pop        = drop_vld || (exec_vld && xif.exec_ready_i);
    end

    // Next-state logic: resolve a commit or kill, then apply the pop and the push.
    always_comb begin
        state_d       = state_q;
        id_d          = id_q;
        hd_d          = hd_q;
        tl_d          = tl_q;
        count_d       = count_q;
        err_d         = err_q;
        hit_tbl       = 1'b0;
        hit_push      = 1'b0;
        resolve_state = xif.commit_kill_i ? SLOT_KILLED : SLOT_COMMITTED;

        if (xif.commit_valid_i) begin
            // Only PENDING slots can match. A head that pops this cycle is
            // already resolved, so a commit aimed at it counts as an error.
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (!hit_tbl && (state_q[i] == SLOT_PENDING) && (id_q[i] == xif.commit_id_i)) begin
                    state_d[i] = resolve_state;
                    hit_tbl    = 1'b1;
                end
            end
            if (!hit_tbl && push && (xif.issue_id_i == xif.commit_id_i)) begin
                hit_push = 1'b1;
            end
            if (!hit_tbl && !hit_push) begin
                err_d = 1'b1;
            end
        end

        if (pop) begin
            state_d[hd_q] = SLOT_FREE;
            hd_d          = hd_q + PW'(1);
        end

        // When the table is full no push occurs, so slot tl is always FREE
        // here and never collides with the popped head.
        if (push) begin
            state_d[tl_q] = hit_push ? resolve_state : SLOT_PENDING;
            id_d[tl_q]    = xif.issue_id_i;
            tl_d          = tl_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State register with a synchronous reset that discards every entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                state_q[i] <= SLOT_FREE;
                id_q[i]    <= '0;
            end
            hd_q    <= '0;
            tl_q    <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            hd_q    <= hd_d;
            tl_q    <= tl_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign xif.issue_ready_o  = issue_rdy;
    assign xif.exec_valid_o   = exec_vld;
    assign xif.exec_id_o      = exec_vld ? id_q[hd_q] : '0;
    assign xif.drop_valid_o   = drop_vld;
    assign xif.drop_id_o      = drop_vld ? id_q[hd_q] : '0;
    assign xif.count_o        = count_q;
    assign xif.commit_error_o = err_q;
endmodule

// File: tb/tb_cv32e40x_xif_commit_tracker.sv
module tb_cv32e40x_xif_commit_tracker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    cv32e40x_xif_commit_tracker_if #(.DEPTH(4), .ID_WIDTH(4)) xif ();

    cv32e40x_xif_commit_tracker #(.DEPTH(4), .ID_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .xif (xif.slave)
    );

    // Advance one rising edge; the bench samples and drives 1 ns after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        xif.issue_valid_i  = 1'b0;
        xif.issue_id_i     = '0;
        xif.commit_valid_i = 1'b0;
        xif.commit_id_i    = '0;
        xif.commit_kill_i  = 1'b0;
        xif.exec_ready_i   = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++; if (xif.issue_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_issue_ready got %b want 1", xif.issue_ready_o); end
        n_chk++; if (xif.exec_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_exec_valid got %b want 0", xif.exec_valid_o); end
        n_chk++; if (xif.drop_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_drop_valid got %b want 0", xif.drop_valid_o); end
        n_chk++; if (xif.exec_id_o !== 4'd0) begin n_fail++; $display("FAIL rst_exec_id got %0d want 0", xif.exec_id_o); end
        n_chk++; if (xif.drop_id_o !== 4'd0) begin n_fail++; $display("FAIL rst_drop_id got %0d want 0", xif.drop_id_o); end
        n_chk++; if (xif.count_o !== 3'd0) begin n_fail++; $display("FAIL rst_count got %0d want 0", xif.count_o); end
        n_chk++; if (xif.commit_error_o !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b want 0", xif.commit_error_o); end
    endtask

    task automatic test_in_order();
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            xif.issue_valid_i = 1'b1; xif.issue_id_i = 4'(k);
            cyc();
            n_chk++; if (xif.count_o !== 3'(k)) begin n_fail++; $display("FAIL ino_count_fill got %0d want %0d", xif.count_o, k); end
        end
        xif.issue_valid_i = 1'b0;
        n_chk++; if (xif.exec_valid_o !== 1'b0) begin n_fail++; $display("FAIL ino_no_exec got %b want 0", xif.exec_valid_o); end
        xif.exec_ready_i = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            xif.commit_valid_i = 1'b1; xif.commit_id_i = 4'(k); xif.commit_kill_i = 1'b0;
            cyc();
            n_chk++; if (xif.exec_valid_o !== 1'b1) begin n_fail++; $display("FAIL ino_exec_valid got %b want 1", xif.exec_valid_o); end
            n_chk++; if (xif.exec_id_o !== 4'(k)) begin n_fail++; $display("FAIL ino_exec_id got %0d want %0d", xif.exec_id_o, k); end
            n_chk++; if (xif.count_o !== 3'(4 - k)) begin n_fail++; $display("FAIL ino_count got %0d want %0d", xif.count_o, 4 - k); end
        end
        xif.commit_valid_i = 1'b0;
        cyc();
        n_chk++; if (xif.count_o !== 3'd0) begin n_fail++; $display("FAIL ino_count_end got %0d want 0", xif.count_o); end
        n_chk++; if (xif.exec_valid_o !== 1'b0) begin n_fail++; $display("FAIL ino_exec_end got %b want 0", xif.exec_valid_o); end
        n_chk++; if (xif.commit_error_o !== 1'b0) begin n_fail++; $display("FAIL ino_err got %b want 0", xif.commit_error_o); end
    endtask

    task automatic test_out_of_order();
        do_reset();
        xif.issue_valid_i = 1'b1; xif.issue_id_i = 4'd5; cyc();
        xif.issue_id_i = 4'd6; cyc();
        xif.issue_valid_i = 1'b0;
        xif.exec_ready_i = 1'b1;
        xif.commit_valid_i = 1'b1; xif.commit_id_i = 4'd6; cyc();
        xif.commit_valid_i = 1'b0;
        n_chk++; if (xif.exec_valid_o !== 1'b0) begin n_fail++; $display("FAIL ooo_wait1 got %b want 0", xif.exec_valid_o); end
        cyc();
        n_chk++; if (xif.exec_valid_o !== 1'b0) begin n_fail++; $display("FAIL ooo_wait2 got %b want 0", xif.exec_valid_o); end
        xif.commit_valid_i = 1'b1; xif.commit_id_i = 4'd5; cyc();
        xif.commit_valid_i = 1'b0;
        n_chk++; if (xif.exec_valid_o !== 1'b1 || xif.exec_id_o !== 4'd5) begin n_fail++; $display("FAIL ooo_exec5 got v=%b id=%0d want v=1 id=5", xif.exec_valid_o, xif.exec_id_o); end
        cyc();
        n_chk++; if (xif.exec_valid_o !== 1'b1 || xif.exec_id_o !== 4'd6) begin n_fail++; $display("FAIL ooo_exec6 got v=%b id=%0d want v=1 id=6", xif.exec_valid_o, xif.exec_id_o); end
        cyc();
        n_chk++; if (xif.exec_valid_o !== 1'b0 || xif.count_o !== 3'd0) begin n_fail++; $display("FAIL ooo_end got v=%b cnt=%0d want v=0 cnt=0", xif.exec_valid_o, xif.count_o); end
    endtask

    task automatic test_kill();
        do_reset();
        for (int k = 7; k <= 9; k++) begin
            xif.issue_valid_i = 1'b1; xif.issue_id_i = 4'(k); cyc();
        end
        xif.issue_valid_i = 1'b0;
        xif.commit_valid_i = 1'b1; xif.commit_id_i = 4'd7; xif.commit_kill_i = 1'b0; cyc();
        n_chk++; if (xif.exec_valid_o !== 1'b1 || xif.exec_id_o !== 4'd7) begin n_fail++; $display("FAIL kill_exec7 got v=%b id=%0d want v=1 id=7", xif.exec_valid_o, xif.exec_id_o); end
        xif.commit_id_i = 4'd8; xif.commit_kill_i = 1'b1; cyc();
        n_chk++; if (xif.exec_valid_o !== 1'b1 || xif.exec_id_o !== 4'd7) begin n_fail++; $display("FAIL kill_hold7 got v=%b id=%0d want v=1 id=7", xif.exec_valid_o, xif.exec_id_o); end
        xif.commit_id_i = 4'd9; xif.commit_kill_i = 1'b0; cyc();
        xif.commit_valid_i = 1'b0;
        n_chk++; if (xif.count_o !== 3'd3 || xif.drop_valid_o !== 1'b0) begin n_fail++; $display("FAIL kill_held got cnt=%0d drop=%b want cnt=3 drop=0", xif.count_o, xif.drop_valid_o); end
        xif.exec_ready_i = 1'b1; cyc();
        n_chk++; if (xif.drop_valid_o !== 1'b1 || xif.drop_id_o !== 4'd8) begin n_fail++; $display("FAIL kill_drop8 got v=%b id=%0d want v=1 id=8", xif.drop_valid_o, xif.drop_id_o); end
        n_chk++; if (xif.exec_valid_o !== 1'b0) begin n_fail++; $display("FAIL kill_noexec got %b want 0", xif.exec_valid_o); end
        cyc();
        n_chk++; if (xif.drop_valid_o !== 1'b0) begin n_fail++; $display("FAIL kill_drop_once got %b want 0", xif.drop_valid_o); end
        n_chk++; if (xif.exec_valid_o !== 1'b1 || xif.exec_id_o !== 4'd9) begin n_fail++; $display("FAIL kill_exec9 got v=%b id=%0d want v=1 id=9", xif.exec_valid_o, xif.exec_id_o); end
        cyc();
        n_chk++; if (xif.count_o !== 3'd0) begin n_fail++; $display("FAIL kill_count got %0d want 0", xif.count_o); end
        n_chk++; if (xif.commit_error_o !== 1'b0) begin n_fail++; $display("FAIL kill_err got %b want 0", xif.commit_error_o); end
    endtask

    task automatic test_full_wrap();
        do_reset();
        // Five pushes and five pops per pass shift both pointers by one slot each pass.
        for (int p = 0; p < 3; p++) begin
            int base;
            base = p * 5 + 1;
            xif.exec_ready_i = 1'b0;
            for (int k = 0; k < 4; k++) begin
                xif.issue_valid_i = 1'b1; xif.issue_id_i = 4'(base + k); cyc();
            end
            xif.issue_id_i = 4'(base + 4);
            n_chk++; if (xif.issue_ready_o !== 1'b0 || xif.count_o !== 3'd4) begin n_fail++; $display("FAIL wrap_full got rdy=%b cnt=%0d want rdy=0 cnt=4", xif.issue_ready_o, xif.count_o); end
            xif.commit_valid_i = 1'b1; xif.commit_id_i = 4'(base); xif.commit_kill_i = 1'b0; cyc();
            xif.commit_valid_i = 1'b0;
            n_chk++; if (xif.issue_ready_o !== 1'b0 || xif.count_o !== 3'd4) begin n_fail++; $display("FAIL wrap_held got rdy=%b cnt=%0d want rdy=0 cnt=4", xif.issue_ready_o, xif.count_o); end
            n_chk++; if (xif.exec_valid_o !== 1'b1 || xif.exec_id_o !== 4'(base)) begin n_fail++; $display("FAIL wrap_head got v=%b id=%0d want v=1 id=%0d", xif.exec_valid_o, xif.exec_id_o, base); end
            xif.exec_ready_i = 1'b1; cyc();
            n_chk++; if (xif.issue_ready_o !== 1'b1 || xif.count_o !== 3'd3) begin n_fail++; $display("FAIL wrap_pop got rdy=%b cnt=%0d want rdy=1 cnt=3", xif.issue_ready_o, xif.count_o); end
            xif.exec_ready_i = 1'b0; cyc();
            xif.issue_valid_i = 1'b0;
            n_chk++; if (xif.issue_ready_o !== 1'b0 || xif.count_o !== 3'd4) begin n_fail++; $display("FAIL wrap_refill got rdy=%b cnt=%0d want rdy=0 cnt=4", xif.issue_ready_o, xif.count_o); end
            xif.exec_ready_i = 1'b1;
            for (int k = 1; k <= 4; k++) begin
                xif.commit_valid_i = 1'b1; xif.commit_id_i = 4'(base + k); cyc();
                n_chk++; if (xif.exec_valid_o !== 1'b1 || xif.exec_id_o !== 4'(base + k)) begin n_fail++; $display("FAIL wrap_drain got v=%b id=%0d want v=1 id=%0d", xif.exec_valid_o, xif.exec_id_o, base + k); end
            end
            xif.commit_valid_i = 1'b0; cyc();
            n_chk++; if (xif.count_o !== 3'd0 || xif.exec_valid_o !== 1'b0) begin n_fail++; $display("FAIL wrap_empty got cnt=%0d v=%b want cnt=0 v=0", xif.count_o, xif.exec_valid_o); end
        end
        xif.exec_ready_i = 1'b0;
        n_chk++; if (xif.commit_error_o !== 1'b0) begin n_fail++; $display("FAIL wrap_err got %b want 0", xif.commit_error_o); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        xif.issue_valid_i = 1'b1; xif.issue_id_i = 4'd2;
        xif.commit_valid_i = 1'b1; xif.commit_id_i = 4'd2; xif.commit_kill_i = 1'b0;
        cyc();
        xif.issue_valid_i = 1'b0;
        n_chk++; if (xif.exec_valid_o !== 1'b1 || xif.exec_id_o !== 4'd2) begin n_fail++; $display("FAIL same_exec got v=%b id=%0d want v=1 id=2", xif.exec_valid_o, xif.exec_id_o); end
        n_chk++; if (xif.count_o !== 3'd1 || xif.commit_error_o !== 1'b0) begin n_fail++; $display("FAIL same_state got cnt=%0d err=%b want cnt=1 err=0", xif.count_o, xif.commit_error_o); end
        cyc();
        xif.commit_valid_i = 1'b0;
        n_chk++; if (xif.commit_error_o !== 1'b1) begin n_fail++; $display("FAIL same_dup_err got %b want 1", xif.commit_error_o); end
        n_chk++; if (xif.exec_valid_o !== 1'b1 || xif.exec_id_o !== 4'd2) begin n_fail++; $display("FAIL same_unchanged got v=%b id=%0d want v=1 id=2", xif.exec_valid_o, xif.exec_id_o); end
        xif.exec_ready_i = 1'b1; cyc();
        xif.exec_ready_i = 1'b0; cyc();
        n_chk++; if (xif.commit_error_o !== 1'b1 || xif.count_o !== 3'd0) begin n_fail++; $display("FAIL same_sticky got err=%b cnt=%0d want err=1 cnt=0", xif.commit_error_o, xif.count_o); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            xif.issue_valid_i = 1'b1; xif.issue_id_i = 4'(k); cyc();
        end
        xif.issue_valid_i = 1'b0;
        xif.commit_valid_i = 1'b1; xif.commit_id_i = 4'd1; cyc();
        xif.commit_id_i = 4'd12; cyc();
        xif.commit_valid_i = 1'b0;
        n_chk++; if (xif.commit_error_o !== 1'b1 || xif.exec_valid_o !== 1'b1) begin n_fail++; $display("FAIL mid_pre got err=%b v=%b want err=1 v=1", xif.commit_error_o, xif.exec_valid_o); end
        rst = 1'b1; cyc(); rst = 1'b0;
        n_chk++; if (xif.count_o !== 3'd0) begin n_fail++; $display("FAIL mid_count got %0d want 0", xif.count_o); end
        n_chk++; if (xif.exec_valid_o !== 1'b0 || xif.drop_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_valid got e=%b d=%b want 0 0", xif.exec_valid_o, xif.drop_valid_o); end
        n_chk++; if (xif.issue_ready_o !== 1'b1) begin n_fail++; $display("FAIL mid_ready got %b want 1", xif.issue_ready_o); end
        n_chk++; if (xif.commit_error_o !== 1'b0) begin n_fail++; $display("FAIL mid_err got %b want 0", xif.commit_error_o); end
        cyc();
        n_chk++; if (xif.drop_valid_o !== 1'b0 || xif.count_o !== 3'd0) begin n_fail++; $display("FAIL mid_after got d=%b cnt=%0d want 0 0", xif.drop_valid_o, xif.count_o); end
    endtask

    initial begin
        idle();
        test_reset();
        test_in_order();
        test_out_of_order();
        test_kill();
        test_full_wrap();
        test_same_cycle();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cv32e40x_xif_commit_tracker.md
# cv32e40x_xif_commit_tracker

Coprocessor-side receiver for the core's eXtension interface commit channel. Accepted offloaded instruction IDs wait in an in-order table until the core commits or kills them. Committed instructions are released to the coprocessor execution unit in issue order; killed instructions are dropped silently. The block sits in the coprocessor, opposite the core controller's commit driver.

## Interface
- `DEPTH`, 4: number of outstanding instructions tracked (power of two, 2..16)
- `ID_WIDTH`, 4: instruction ID width
- `clk` in 1: clock
- `rst` in 1: reset, synchronous, active-high
- `issue_valid_i` in 1: offloaded instruction accepted by coprocessor this cycle
- `issue_ready_o` out 1: table can take an entry
- `issue_id_i` in ID_WIDTH: ID of issued instruction
- `commit_valid_i` in 1: commit transaction from core
- `commit_id_i` in ID_WIDTH: ID being committed/killed
- `commit_kill_i` in 1: 1 = kill, 0 = commit
- `exec_valid_o` out 1: head entry committed, ready to execute
- `exec_ready_i` in 1: execution unit takes head
- `exec_id_o` out ID_WIDTH: ID of head entry
- `drop_valid_o` out 1: killed head being discarded this cycle
- `drop_id_o` out ID_WIDTH: ID being discarded
- `count_o` out $clog2(DEPTH+1): occupied entries
- `commit_error_o` out 1: sticky; commit/kill for unknown or already resolved ID

## Operation
- Entry state per slot: FREE, PENDING, COMMITTED, KILLED; ID stored per slot.
- Circular buffer: head pointer `hd`, tail pointer `tl`, `$clog2(DEPTH)` bits, wrap modulo DEPTH; `count` tracked separately (full = count==DEPTH, empty = count==0).
- Push: `issue_valid_i && issue_ready_o` writes slot `tl` as PENDING with `issue_id_i`, `tl`++.
- `issue_ready_o = (count < DEPTH)` from registered count only; no same-cycle pop bypass.
- Commit/kill: `commit_valid_i` searches the occupied slots for a PENDING entry with matching ID (IDs unique among outstanding entries) and sets it to COMMITTED (kill=0) or KILLED (kill=1).
- Same-cycle issue + commit of the same ID: pushed slot is written directly as COMMITTED/KILLED.
- No match (ID absent, or entry already COMMITTED/KILLED): table unchanged, `commit_error_o` set and held until reset.
- Head COMMITTED: `exec_valid_o`=1, `exec_id_o`=slot ID; pop on `exec_ready_i`.
- Head KILLED: `drop_valid_o`=1, `drop_id_o`=slot ID, pop unconditionally in that cycle.
- Head PENDING or table empty: `exec_valid_o`=`drop_valid_o`=0; younger committed entries wait (strict in-order).
- Pop frees slot `hd` (state FREE), `hd`++.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Commit targeting the head in the cycle it pops is impossible (head already resolved) and is flagged as an error.

## Timing
- Reset (synchronous, `rst`=1 at a rising edge): all slots FREE, `hd`=`tl`=0, count 0, `commit_error_o`=0. Outputs after reset: `issue_ready_o`=1, `exec_valid_o`=0, `drop_valid_o`=0, `exec_id_o`=`drop_id_o`=0, `count_o`=0.
- Reset mid-operation discards all entries; no drop pulses are produced.
- All outputs derive from registered state only. No combinational path from `commit_*` or `exec_ready_i` to any output.
- Commit at cycle N on the head entry -> `exec_valid_o` at N+1.
- Kill at cycle N on the head entry -> `drop_valid_o` for exactly cycle N+1.
- Pop at cycle N -> next head visible at N+1; back-to-back resolved entries drain one per cycle.
- `exec_valid_o` and `exec_id_o` stay stable while `exec_ready_i`=0.
- Push at N -> `count_o` +1 at N+1. Full at N -> `issue_ready_o`=0 at N, even if a pop occurs at N.

## Test plan
- Issue IDs 1,2,3; commit 1,2,3 in order -> `exec_valid_o` at one cycle after each commit, `exec_id_o` 1,2,3, `count_o` 3->0.
- Issue 5,6; commit 6 then 5 two cycles later -> no exec until commit 5 +1 cycle, then 5 then 6 on consecutive cycles with `exec_ready_i`=1.
- Issue 7,8,9; kill 8, commit 7 and 9 -> exec 7, drop pulse id 8 for one cycle, exec 9; `commit_error_o`=0.
- Fill 4 entries -> `issue_ready_o`=0 while `issue_valid_i` is held; pop one -> `issue_ready_o`=1 the next cycle, pointer wrap exercised over 3 full passes.
- Same-cycle issue + commit of ID 2 on an empty table -> `exec_valid_o`=1 with id 2 next cycle. Commit ID 2 again -> `commit_error_o`=1 and sticky.
- Assert `rst` with 3 entries outstanding and `exec_ready_i`=0 -> next cycle `count_o`=0, `exec_valid_o`=0, `issue_ready_o`=1, `commit_error_o`=0.
